uart_line_reverser: RTL and testbench
=====================================

# uart_line_reverser

Stream stage between `uart_rx` and `uart_tx` in the UART loopback design. It collects received bytes into a line buffer until a CR or LF terminator arrives. It then transmits the line in reverse byte order, with optional upper-to-lower case conversion, followed by CR LF. Upstream is throttled through `i_tready` while a line is being drained, so the `uart_rx` FIFO absorbs bytes that arrive during transmission.

## Interface
- `DEPTH_LOG`, default 6: line buffer holds DEPTH = 2**DEPTH_LOG bytes (allowed range 2..8).
- `LOWERCASE`, default 1: 1 converts output bytes 0x41..0x5A to byte+0x20; 0 passes bytes unchanged. CR/LF appended by the block are never converted.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous reset, active-high.
- `i_tready` out 1: block accepts an input byte this cycle.
- `i_tvalid` in 1: input byte valid (from `uart_rx` `o_tvalid`).
- `i_tdata` in 8: input byte.
- `o_tready` in 1: downstream accepts an output byte (from `uart_tx` `i_tready`).
- `o_tvalid` out 1: output byte valid.
- `o_tdata` out 8: output byte.
- `o_tlast` out 1: marks the final LF of each emitted line.
- `o_overflow` out 1: one-cycle pulse when a line is force-flushed because the buffer is full.

## Operation
- The buffer is `mem[0..DEPTH-1]` of 8-bit entries. `cnt` is DEPTH_LOG+1 bits wide and holds the stored byte count.
- A transfer occurs when valid and ready are both high at a rising edge, on either side.
- States: FILL, DRAIN, CR, LF.
- FILL:
  - `i_tready` = 1 (0 while `rst` is high). `o_tvalid` = 0.
  - Accepted byte 0x0D or 0x0A with `cnt`==0: dropped; no output is produced, so CRLF pairs never yield empty lines.
  - Accepted byte 0x0D or 0x0A with `cnt`>0: goes to DRAIN; the terminator is not stored.
  - Any other accepted byte: `mem[cnt]` <= byte and `cnt` <= `cnt`+1.
  - If that store makes `cnt` equal DEPTH: goes to DRAIN and pulses `o_overflow` for one cycle.
- DRAIN:
  - `i_tready` = 0. `o_tvalid` = 1 and `o_tdata` = conv(`mem[cnt-1]`).
  - On each output transfer, `cnt` decrements.
  - On the transfer where `cnt` goes 1->0: goes to CR.
- CR: `o_tvalid` = 1, `o_tdata` = 0x0D. On transfer: goes to LF.
- LF: `o_tvalid` = 1, `o_tdata` = 0x0A, `o_tlast` = 1. On transfer: goes to FILL.
- `o_tlast` = 0 in all states other than LF.
- Input and output phases are mutually exclusive, so no simultaneous input/output transfer can occur.
- After a force-flush, following bytes start a new line. A terminator that arrives later only ends that new line, or is dropped if the new line is empty.

## Timing
- Reset values: state FILL, `cnt` 0, `o_tvalid` 0, `o_tdata` 0x00, `o_tlast` 0, `o_overflow` 0. `i_tready` is 0 while `rst` is high and 1 in the first cycle after `rst` deasserts.
- `o_tvalid`, `o_tdata`, `o_tlast` and `o_overflow` are driven from registers.
- `i_tready` is decoded from the state register.
- Latency: the terminator transfer occurs at edge k. In the cycle after edge k, `o_tvalid` = 1 and `o_tdata` = conv(last stored byte).
- Throughput: 1 byte per cycle while `o_tready` = 1. A line of L bytes takes exactly L+2 output cycles. `i_tready` returns to 1 in the cycle after the LF transfer.
- Backpressure: while `o_tvalid` = 1 and `o_tready` = 0, `o_tdata` and `o_tlast` hold stable. `o_tvalid` never drops without a transfer, except on reset.
- Overflow: `o_overflow` is high for exactly the one cycle after the DEPTH-th byte is stored, which is the first cycle of DRAIN.
- Reset mid-line or mid-drain: the buffer contents are discarded. The reset-value rule applies, so `o_tvalid` is 0 in the cycle after the reset edge and no partial CR/LF is emitted.

## Test plan
- Input "AbC\r\n" (0x41 0x62 0x43 0x0D 0x0A) with LOWERCASE=1 and `o_tready`=1 -> output 0x63 0x62 0x61 0x0D 0x0A, with `o_tlast` only on 0x0A. The trailing 0x0A is dropped and produces no output.
- Input "\n\r\n" only -> no output transfer and `i_tready` stays 1.
- DEPTH_LOG=2, input "123456\n" -> "4321\r\n" with `o_overflow` pulsed once, then "65\r\n".
- Line "xyz\n" with `o_tready` toggled 1,0,0,1 per cycle -> `o_tdata` stable during stalls. Output is exactly "zyx\r\n" and `i_tready` is 0 throughout the drain.
- LOWERCASE=0, input "Q[\n" -> output 0x5B 0x51 0x0D 0x0A.
- `rst` pulsed after 2 bytes of "hello" are stored, then input "ok\n" -> output "ko\r\n" only, with no residue from "he".

Source files
------------

// File: rtl/uart_line_reverser.sv
// uart_line_reverser: buffers a received line, then emits it
// reversed (optionally lowercased) followed by CR LF.
module uart_line_reverser #(
   parameter int DEPTH_LOG = 6,
   parameter bit LOWERCASE = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   output logic       i_tready,
   input  logic       i_tvalid,
   input  logic [7:0] i_tdata,
   input  logic       o_tready,
   output logic       o_tvalid,
   output logic [7:0] o_tdata,
   output logic       o_tlast,
   output logic       o_overflow
);

   localparam int DEPTH = 2 ** DEPTH_LOG;
   localparam logic [DEPTH_LOG:0] CNT_ONE = (DEPTH_LOG+1)'(1);
   localparam logic [DEPTH_LOG:0] CNT_TOP = (DEPTH_LOG+1)'(DEPTH - 1);

   typedef enum logic [1:0] {
      FILL,
      DRAIN,
      CR,
      LF
   } state_t;

   state_t                 state;
   logic [DEPTH_LOG:0]     cnt;
   logic [7:0]             mem [DEPTH];
   logic                   in_xfer;
   logic                   out_xfer;
   logic                   is_term;
   logic [DEPTH_LOG-1:0]   wr_idx;
   logic [DEPTH_LOG-1:0]   rd_last;
   logic [DEPTH_LOG-1:0]   rd_next;

   function automatic logic [7:0] conv(input logic [7:0] b);
      if (LOWERCASE && b >= 8'h41 && b <= 8'h5A)
         return b + 8'h20;
      return b;
   endfunction

   assign i_tready = (state == FILL) && !rst;
   assign in_xfer  = i_tvalid && i_tready;
   assign out_xfer = o_tvalid && o_tready;
   assign is_term  = (i_tdata == 8'h0D) || (i_tdata == 8'h0A);
   assign wr_idx   = cnt[DEPTH_LOG-1:0];
   assign rd_last  = DEPTH_LOG'(cnt - CNT_ONE);
   assign rd_next  = DEPTH_LOG'(cnt - (DEPTH_LOG+1)'(2));

   // Line buffer write port; contents need no reset since cnt gates reads.
   always_ff @(posedge clk) begin
      if (state == FILL && in_xfer && !is_term && !rst)
         mem[wr_idx] <= i_tdata;
   end

   // Fill/drain sequencing with registered output bundle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FILL;
         cnt        <= '0;
         o_tvalid   <= 1'b0;
         o_tdata    <= 8'h00;
         o_tlast    <= 1'b0;
         o_overflow <= 1'b0;
      end else begin
         o_overflow <= 1'b0;
         unique case (state)
            FILL: begin
               if (in_xfer) begin
                  if (is_term) begin
                     if (cnt != '0) begin
                        state    <= DRAIN;
                        o_tvalid <= 1'b1;
                        o_tdata  <= conv(mem[rd_last]);
                     end
                  end else begin
                     cnt <= cnt + CNT_ONE;
                     if (cnt == CNT_TOP) begin
                        state      <= DRAIN;
                        o_tvalid   <= 1'b1;
                        o_tdata    <= conv(i_tdata);
                        o_overflow <= 1'b1;
                     end
                  end
               end
            end
            DRAIN: begin
               if (out_xfer) begin
                  cnt <= cnt - CNT_ONE;
                  if (cnt == CNT_ONE) begin
                     state   <= CR;
                     o_tdata <= 8'h0D;
                  end else begin
                     o_tdata <= conv(mem[rd_next]);
                  end
               end
            end
            CR: begin
               if (out_xfer) begin
                  state   <= LF;
                  o_tdata <= 8'h0A;
                  o_tlast <= 1'b1;
               end
            end
            LF: begin
               if (out_xfer) begin
                  state    <= FILL;
                  o_tvalid <= 1'b0;
                  o_tlast  <= 1'b0;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_line_reverser.sv
// tb_uart_line_reverser: directed stimulus with a reference model
// feeding per-instance expected-byte queues.
module tb_uart_line_reverser;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_tvalid;
   logic [7:0] i_tdata;
   logic       o_tready;
   logic       rdy0, vld0, last0, ovf0;
   logic [7:0] dat0;
   logic       rdy1, vld1, last1, ovf1;
   logic [7:0] dat1;

   int         checks = 0;
   int         errors = 0;
   logic [8:0] exp0[$];
   logic [8:0] exp1[$];
   logic [7:0] lb[$];
   bit         ovf_next, lat, accepted;
   bit         hold0, hold1;
   logic [8:0] held0, held1;
   int         ovf_seen0, ovf_seen1;

   always #5 clk = ~clk;

   uart_line_reverser #(.DEPTH_LOG(2)) u0 (
      .clk(clk), .rst(rst),
      .i_tready(rdy0), .i_tvalid(i_tvalid), .i_tdata(i_tdata),
      .o_tready(o_tready), .o_tvalid(vld0), .o_tdata(dat0),
      .o_tlast(last0), .o_overflow(ovf0)
   );

   uart_line_reverser #(.DEPTH_LOG(2), .LOWERCASE(1'b0)) u1 (
      .clk(clk), .rst(rst),
      .i_tready(rdy1), .i_tvalid(i_tvalid), .i_tdata(i_tdata),
      .o_tready(o_tready), .o_tvalid(vld1), .o_tdata(dat1),
      .o_tlast(last1), .o_overflow(ovf1)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] conv(input logic [7:0] b, input bit lc);
      if (lc && b >= 8'h41 && b <= 8'h5A) return b + 8'h20;
      return b;
   endfunction

   task automatic model(input logic [7:0] b);
      bit flush;
      flush = 1'b0;
      if (b == 8'h0D || b == 8'h0A) begin
         flush = (lb.size() > 0);
      end else begin
         lb.push_back(b);
         if (lb.size() == 4) begin
            flush    = 1'b1;
            ovf_next = 1'b1;
         end
      end
      if (flush) begin
         for (int i = lb.size() - 1; i >= 0; i--) begin
            exp0.push_back({1'b0, conv(lb[i], 1'b1)});
            exp1.push_back({1'b0, conv(lb[i], 1'b0)});
         end
         exp0.push_back(9'h00D); exp0.push_back(9'h10A);
         exp1.push_back(9'h00D); exp1.push_back(9'h10A);
         lb.delete();
         lat = 1'b1;
      end
   endtask

   task automatic mon(input int id, input logic v, input logic r,
                      input logic [8:0] d);
      logic [8:0] e;
      bit         h;
      h = (id == 0) ? hold0 : hold1;
      chk($sformatf("ready%0d", id), {31'd0, r}, {31'd0, !v});
      if (h) begin
         chk($sformatf("stallvalid%0d", id), {31'd0, v}, 32'd1);
         chk($sformatf("stalldata%0d", id), {23'd0, d},
             {23'd0, (id == 0) ? held0 : held1});
      end
      if (v && o_tready) begin
         checks++;
         assert (((id == 0) ? exp0.size() : exp1.size()) != 0) else begin
            errors++;
            $error("FAIL extra%0d: observed byte %h expected none", id, d);
         end
         if (id == 0 && exp0.size() != 0) begin
            e = exp0.pop_front();
            chk("out0", {23'd0, d}, {23'd0, e});
         end
         if (id == 1 && exp1.size() != 0) begin
            e = exp1.pop_front();
            chk("out1", {23'd0, d}, {23'd0, e});
         end
      end
      if (id == 0) begin hold0 = v && !o_tready; held0 = d; end
      else begin hold1 = v && !o_tready; held1 = d; end
   endtask

   task automatic cycle();
      bit acc;
      acc = 1'b0;
      @(negedge clk);
      if (!rst) begin
         mon(0, vld0, rdy0, {last0, dat0});
         mon(1, vld1, rdy1, {last1, dat1});
         if (i_tvalid && rdy0) begin
            model(i_tdata);
            acc = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      if (!rst) begin
         chk("ovf0", {31'd0, ovf0}, {31'd0, ovf_next});
         chk("ovf1", {31'd0, ovf1}, {31'd0, ovf_next});
         if (ovf0) ovf_seen0++;
         if (ovf1) ovf_seen1++;
         if (lat) begin
            chk("lat_valid0", {31'd0, vld0}, 32'd1);
            chk("lat_valid1", {31'd0, vld1}, 32'd1);
            chk("lat_data0", {24'd0, dat0}, {24'd0, exp0[0][7:0]});
            chk("lat_data1", {24'd0, dat1}, {24'd0, exp1[0][7:0]});
            lat = 1'b0;
         end
         ovf_next = 1'b0;
      end
      accepted = acc;
   endtask

   task automatic send(input logic [7:0] b);
      int n;
      n        = 0;
      i_tvalid = 1'b1;
      i_tdata  = b;
      accepted = 1'b0;
      while (!accepted && n < 100) begin
         cycle();
         n++;
      end
      checks++;
      assert (accepted) else begin
         errors++;
         $error("FAIL accept: observed timeout expected byte %h taken", b);
      end
      i_tvalid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i]);
   endtask

   task automatic drain(input bit stall);
      int n;
      n = 0;
      while ((exp0.size() != 0 || exp1.size() != 0 || !rdy0) && n < 200) begin
         o_tready = stall ? ((n % 4 == 0) || (n % 4 == 3)) : 1'b1;
         cycle();
         n++;
      end
      o_tready = 1'b1;
      chk("drain_timeout", n < 200, 32'd1);
      repeat (3) cycle();
      chk("idle_ready0", {31'd0, rdy0}, 32'd1);
      chk("idle_ready1", {31'd0, rdy1}, 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_ready0", {31'd0, rdy0}, 32'd0);
      chk("rst_ready1", {31'd0, rdy1}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      lb.delete(); exp0.delete(); exp1.delete();
      hold0 = 1'b0; hold1 = 1'b0; lat = 1'b0; ovf_next = 1'b0;
      chk("rv_valid0", {31'd0, vld0}, 32'd0);
      chk("rv_data0", {24'd0, dat0}, 32'd0);
      chk("rv_last0", {31'd0, last0}, 32'd0);
      chk("rv_ovf0", {31'd0, ovf0}, 32'd0);
      chk("rv_ready0", {31'd0, rdy0}, 32'd1);
      chk("rv_valid1", {31'd0, vld1}, 32'd0);
      chk("rv_ready1", {31'd0, rdy1}, 32'd1);
   endtask

   initial begin
      rst      = 1'b1;
      i_tvalid = 1'b0;
      i_tdata  = 8'h00;
      o_tready = 1'b1;
      hold0    = 1'b0;
      hold1    = 1'b0;
      @(posedge clk);
      do_reset();

      send_str("AbC\r\n");
      drain(1'b0);

      send_str("\n\r\n");
      drain(1'b0);

      ovf_seen0 = 0;
      ovf_seen1 = 0;
      send_str("123456\n");
      drain(1'b0);
      chk("ovf_count0", ovf_seen0, 32'd1);
      chk("ovf_count1", ovf_seen1, 32'd1);

      send_str("xyz\n");
      drain(1'b1);

      send_str("Q[\n");
      drain(1'b0);

      send_str("@Z\n");
      drain(1'b0);

      send_str("he");
      do_reset();
      send_str("ok\n");
      drain(1'b0);

      send_str("ab\n");
      cycle();
      do_reset();
      drain(1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
